// File: rtl/prg_pkg.sv
// Shared constants and types for the PRG frame collector.
// Holds the default frame geometry, FIFO depth, byte/frame/entry widths and
// the assembler FSM state encoding used by prg_frame_collector.
package prg_pkg;

    localparam int FRAME_BYTES = 3;
    localparam int FIFO_DEPTH  = 2;
    localparam int BYTE_W      = 8;
    localparam int FRAME_W     = FRAME_BYTES * BYTE_W;
    // One FIFO entry is the frame plus its precomputed parity bit on top.
    localparam int ENTRY_W     = FRAME_W + 1;
    localparam int COUNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,   // no byte held
        COLLECT   = 2'd1,   // 1..FRAME_BYTES-1 bytes held
        FULL_WAIT = 2'd2    // frame complete, waiting for FIFO space
    } asm_state_t;

endpackage

// File: rtl/prg_frame_collector_if.sv
// Handshake bundle between a generator-side driver and the frame collector.
// master: drives ena, byte_in, byte_valid, frame_ready, clr_ovf and
//         observes the frame outputs.
// slave : the collector; observes the byte stream and drives frame_out,
//         frame_parity, frame_valid, overflow and frame_count.
interface prg_frame_collector_if;
    import prg_pkg::*;

    logic                ena;
    logic [BYTE_W-1:0]   byte_in;
    logic                byte_valid;
    logic                frame_ready;
    logic                clr_ovf;
    logic [FRAME_W-1:0]  frame_out;
    logic                frame_parity;
    logic                frame_valid;
    logic                overflow;
    logic [COUNT_W-1:0]  frame_count;

    modport master (
        output ena, byte_in, byte_valid, frame_ready, clr_ovf,
        input  frame_out, frame_parity, frame_valid, overflow, frame_count
    );

    modport slave (
        input  ena, byte_in, byte_valid, frame_ready, clr_ovf,
        output frame_out, frame_parity, frame_valid, overflow, frame_count
    );
endinterface

// File: rtl/prg_frame_fifo.sv
// Small frame FIFO for the collector.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (empties the FIFO)
//   push        - write push_data (ignored when full unless popping too)
//   push_data   - entry to store (frame + parity)
//   pop         - discard head entry (ignored when empty)
//   head_data   - current head entry, all zeros while empty
//   not_empty   - at least one entry held
//   full        - DEPTH entries held
module prg_frame_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             not_empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [OCC_W-1:0] occ_reg;

    logic push_ok;
    logic pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign not_empty = (occ_reg != '0);
    assign full      = (occ_reg == OCC_W'(DEPTH));
    assign pop_ok    = pop && not_empty;
    // When full, a simultaneous pop frees the slot being written this edge.
    assign push_ok   = push && (!full || pop_ok);

    // Storage carries no reset; validity is tracked by occ_reg alone.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (push_ok && !pop_ok)      occ_reg <= occ_reg + OCC_W'(1);
            else if (!push_ok && pop_ok) occ_reg <= occ_reg - OCC_W'(1);
        end
    end

    // Head forced to zero when empty so stale entries never leak out.
    assign head_data = not_empty ? mem[rd_ptr_reg] : '0;

endmodule

// File: rtl/prg_frame_collector.sv
// Assembles generator output bytes into fixed-size frames and buffers them.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - prg_frame_collector_if.slave:
//                ena/byte_in/byte_valid in, frame_ready/clr_ovf in,
//                frame_out/frame_parity/frame_valid/overflow/frame_count out
// First byte of a frame lands in the MSBs of frame_out. A frame that
// completes while the FIFO is full is held in FULL_WAIT until the next pop;
// bytes arriving during that wait are dropped and flag overflow.
module prg_frame_collector
    import prg_pkg::*;
#(
    parameter int FRAME_BYTES = prg_pkg::FRAME_BYTES,
    parameter int FIFO_DEPTH  = prg_pkg::FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prg_frame_collector_if.slave bus
);
    localparam int FW    = FRAME_BYTES * BYTE_W;
    localparam int CNT_W = (FRAME_BYTES > 2) ? $clog2(FRAME_BYTES) : 1;

    asm_state_t           state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    // Partial frame right-aligned while collecting; full frame in FULL_WAIT.
    logic [FW-1:0]        asm_reg;
    logic                 ovf_reg;
    logic [COUNT_W-1:0]   count_reg;

    logic                 accept;
    logic                 last_byte;
    logic                 complete;
    logic [FW-1:0]        done_frame;
    logic [FW-1:0]        push_frame;
    logic                 push;
    logic                 pop;
    logic                 ovf_set;
    logic [FW:0]          head_data;
    logic                 fifo_not_empty;
    logic                 fifo_full;

    assign accept     = bus.ena && bus.byte_valid;
    assign last_byte  = (cnt_reg == CNT_W'(FRAME_BYTES - 1));
    assign done_frame = {asm_reg[FW-BYTE_W-1:0], bus.byte_in};
    assign complete   = (state_reg == COLLECT) && accept && last_byte;
    assign pop        = fifo_not_empty && bus.frame_ready;
    assign push       = (complete && (!fifo_full || pop)) ||
                        ((state_reg == FULL_WAIT) && pop);
    assign push_frame = (state_reg == FULL_WAIT) ? asm_reg : done_frame;
    assign ovf_set    = (state_reg == FULL_WAIT) && accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            asm_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        asm_reg   <= FW'(bus.byte_in);
                        cnt_reg   <= CNT_W'(1);
                        state_reg <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (!bus.ena) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else if (accept) begin
                        if (last_byte) begin
                            cnt_reg <= '0;
                            if (push) begin
                                state_reg <= IDLE;
                            end else begin
                                asm_reg   <= done_frame;
                                state_reg <= FULL_WAIT;
                            end
                        end else begin
                            asm_reg <= done_frame;
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                FULL_WAIT: begin
                    if (pop) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // A new overflow event wins over a same-edge clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg   <= 1'b0;
            count_reg <= '0;
        end else begin
            if (ovf_set)          ovf_reg <= 1'b1;
            else if (bus.clr_ovf) ovf_reg <= 1'b0;
            if (push) count_reg <= count_reg + COUNT_W'(1);
        end
    end

    prg_frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({^push_frame, push_frame}),
        .pop       (pop),
        .head_data (head_data),
        .not_empty (fifo_not_empty),
        .full      (fifo_full)
    );

    assign bus.frame_out    = head_data[FW-1:0];
    assign bus.frame_parity = head_data[FW];
    assign bus.frame_valid  = fifo_not_empty;
    assign bus.overflow     = ovf_reg;
    assign bus.frame_count  = count_reg;

endmodule

// File: tb/tb_prg_frame_collector.sv
// Self-checking bench for prg_frame_collector: directed stimulus with a
// scoreboard of expected frames, compared whenever the DUT pops a frame.
module tb_prg_frame_collector;
    logic clk;
    logic rst_n;

    prg_frame_collector_if bus();

    prg_frame_collector #(
        .FRAME_BYTES (3),
        .FIFO_DEPTH  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [23:0] sb_q[$];
    logic [7:0]  exp_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] f);
        logic [23:0] v;
        v = f;
        send_byte(v[23:16]);
        send_byte(v[15:8]);
        send_byte(v[7:0]);
    endtask

    // Scoreboard side: every pop edge must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n && bus.frame_valid && bus.frame_ready) begin
            logic [23:0] e;
            check("pop_has_expect", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                $display("pop frame_out=%h parity=%b expect=%h", bus.frame_out, bus.frame_parity, e);
                check("pop_frame", 32'(bus.frame_out), 32'(e));
                check("pop_parity", 32'(bus.frame_parity), 32'(^e));
            end
        end
    end

    initial begin
        logic [23:0] f;
        rst_n           = 1'b0;
        bus.ena         = 1'b0;
        bus.byte_in     = '0;
        bus.byte_valid  = 1'b0;
        bus.frame_ready = 1'b0;
        bus.clr_ovf     = 1'b0;
        exp_count       = '0;
        tick(2);

        // Reset state
        check("rst_valid", 32'(bus.frame_valid), 32'd0);
        check("rst_out", 32'(bus.frame_out), 32'd0);
        check("rst_parity", 32'(bus.frame_parity), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_count", 32'(bus.frame_count), 32'd0);
        rst_n   = 1'b1;
        bus.ena = 1'b1;
        tick(1);

        // Basic frame, latency 1
        bus.frame_ready = 1'b1;
        sb_q.push_back(24'hA53C0F);
        send_frame(24'hA53C0F);
        exp_count++;
        check("basic_valid", 32'(bus.frame_valid), 32'd1);
        check("basic_out", 32'(bus.frame_out), 32'hA53C0F);
        check("basic_parity", 32'(bus.frame_parity), 32'd0);
        check("basic_count", 32'(bus.frame_count), 32'(exp_count));
        tick(2);
        check("basic_empty", 32'(bus.frame_valid), 32'd0);
        check("basic_zero_out", 32'(bus.frame_out), 32'd0);

        // Backpressure: two buffered, third held, tenth byte overflows
        bus.frame_ready = 1'b0;
        sb_q.push_back(24'h102030);
        sb_q.push_back(24'h405060);
        sb_q.push_back(24'h708091);
        send_frame(24'h102030); exp_count++;
        send_frame(24'h405060); exp_count++;
        send_frame(24'h708091);
        check("bp_head", 32'(bus.frame_out), 32'h102030);
        check("bp_parity", 32'(bus.frame_parity), 32'(^24'h102030));
        check("bp_count", 32'(bus.frame_count), 32'(exp_count));
        check("bp_no_ovf", 32'(bus.overflow), 32'd0);
        send_byte(8'hEE);
        check("bp_ovf", 32'(bus.overflow), 32'd1);
        check("bp_head_kept", 32'(bus.frame_out), 32'h102030);
        bus.frame_ready = 1'b1;
        tick(1);
        bus.frame_ready = 1'b0;
        exp_count++;
        check("bp_after_pop", 32'(bus.frame_out), 32'h405060);
        check("bp_count3", 32'(bus.frame_count), 32'(exp_count));
        bus.frame_ready = 1'b1;
        tick(3);
        check("bp_drained", 32'(bus.frame_valid), 32'd0);
        check("bp_ovf_sticky", 32'(bus.overflow), 32'd1);
        bus.clr_ovf = 1'b1;
        tick(1);
        bus.clr_ovf = 1'b0;
        check("bp_ovf_clr", 32'(bus.overflow), 32'd0);

        // ena low aborts a partial frame
        send_byte(8'h11);
        send_byte(8'h22);
        bus.ena = 1'b0;
        tick(1);
        bus.ena = 1'b1;
        sb_q.push_back(24'h334455);
        send_frame(24'h334455);
        exp_count++;
        check("abort_out", 32'(bus.frame_out), 32'h334455);
        check("abort_count", 32'(bus.frame_count), 32'(exp_count));
        tick(2);

        // Final byte accepted on the same edge as a pop with FIFO full
        bus.frame_ready = 1'b0;
        sb_q.push_back(24'hAABBCC);
        sb_q.push_back(24'hDDEEF0);
        sb_q.push_back(24'h123456);
        send_frame(24'hAABBCC); exp_count++;
        send_frame(24'hDDEEF0); exp_count++;
        send_byte(8'h12);
        send_byte(8'h34);
        bus.frame_ready = 1'b1;
        send_byte(8'h56);
        bus.frame_ready = 1'b0;
        exp_count++;
        check("sim_ovf", 32'(bus.overflow), 32'd0);
        check("sim_head", 32'(bus.frame_out), 32'hDDEEF0);
        check("sim_count", 32'(bus.frame_count), 32'(exp_count));
        bus.frame_ready = 1'b1;
        tick(1);
        bus.frame_ready = 1'b0;
        check("sim_second", 32'(bus.frame_out), 32'h123456);
        bus.frame_ready = 1'b1;
        tick(1);
        bus.frame_ready = 1'b0;
        check("sim_empty", 32'(bus.frame_valid), 32'd0);

        // Asynchronous reset with one frame plus two bytes held
        send_frame(24'hC1C2C3);
        send_byte(8'hD1);
        send_byte(8'hD2);
        check("pre_rst_valid", 32'(bus.frame_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.frame_valid), 32'd0);
        check("arst_out", 32'(bus.frame_out), 32'd0);
        check("arst_parity", 32'(bus.frame_parity), 32'd0);
        check("arst_count", 32'(bus.frame_count), 32'd0);
        tick(1);
        rst_n     = 1'b1;
        exp_count = '0;
        bus.frame_ready = 1'b1;
        sb_q.push_back(24'h010203);
        send_frame(24'h010203);
        exp_count++;
        check("post_rst_out", 32'(bus.frame_out), 32'h010203);
        check("post_rst_count", 32'(bus.frame_count), 32'(exp_count));
        tick(2);

        // Count wrap after 256 frames in total since reset
        for (int i = 0; i < 255; i++) begin
            f = {8'(i), 8'(i) ^ 8'h5A, ~8'(i)};
            sb_q.push_back(f);
            send_frame(f);
            exp_count++;
        end
        tick(2);
        check("count_wrap", 32'(bus.frame_count), 32'd0);

        // Overflow event and clr_ovf on the same edge
        bus.frame_ready = 1'b0;
        sb_q.push_back(24'h0A0B0C);
        sb_q.push_back(24'h0D0E0F);
        sb_q.push_back(24'hF1F2F3);
        send_frame(24'h0A0B0C); exp_count++;
        send_frame(24'h0D0E0F); exp_count++;
        send_frame(24'hF1F2F3);
        bus.clr_ovf = 1'b1;
        send_byte(8'h77);
        bus.clr_ovf = 1'b0;
        check("ovf_clr_same_edge", 32'(bus.overflow), 32'd1);
        bus.clr_ovf = 1'b1;
        tick(1);
        bus.clr_ovf = 1'b0;
        check("ovf_clr_later", 32'(bus.overflow), 32'd0);
        bus.frame_ready = 1'b1;
        tick(4);
        exp_count++;
        check("final_count", 32'(bus.frame_count), 32'(exp_count));
        check("final_empty", 32'(bus.frame_valid), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/prg_frame_collector.md
PRG_FRAME_COLLECTOR -- requirements
Module: prg_frame_collector

Interface
REQ-001 Parameter FRAME_BYTES, default 3, SHALL be the number of generator output bytes per frame (out1, out2, out3).
REQ-002 Parameter FIFO_DEPTH, default 2, SHALL be the number of complete frames buffered.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset; it is asynchronous and active-low.
REQ-005 ena  input  1  SHALL enable collection; low aborts any partial frame.
REQ-006 byte_in  input  8  SHALL be the generator output byte.
REQ-007 byte_valid  input  1  SHALL qualify byte_in for one cycle per byte.
REQ-008 frame_ready  input  1  SHALL be the downstream ready signal.
REQ-009 clr_ovf  input  1  SHALL clear the overflow flag.
REQ-010 frame_out  output  24  SHALL be the head frame, first byte in [23:16].
REQ-011 frame_parity  output  1  SHALL be the XOR of all 24 bits of frame_out.
REQ-012 frame_valid  output  1  SHALL be high while the FIFO is non-empty.
REQ-013 overflow  output  1  SHALL be a sticky dropped-frame flag.
REQ-014 frame_count  output  8  SHALL count frames accepted into the FIFO.

Function
REQ-015 A byte SHALL be accepted on a rising edge where ena=1 and byte_valid=1.
REQ-016 The assembler FSM SHALL have states IDLE (no byte held), COLLECT (1..FRAME_BYTES-1 bytes held) and FULL_WAIT (frame complete, FIFO full).
- IDLE->COLLECT on accept.
- COLLECT->IDLE on the accept of the final byte when the push succeeds.
- COLLECT->FULL_WAIT on the accept of the final byte when the FIFO is full and no pop occurs on that edge.
REQ-017 Accepted bytes SHALL fill frame_out from MSB down: byte 0 in [23:16], byte 1 in [15:8], byte 2 in [7:0].
REQ-018 The final byte SHALL be pushed on its accept edge, so frame_valid rises in the following cycle (latency 1 cycle).
REQ-019 A pop SHALL occur on an edge where frame_valid=1 and frame_ready=1; frame_out and frame_parity SHALL update to the next entry on the same edge.
REQ-020 A simultaneous push and pop on a full FIFO SHALL both succeed; occupancy is unchanged and overflow is not set.
REQ-021 In FULL_WAIT the completed frame SHALL be held and pushed on the first pop edge, then the FSM SHALL return to IDLE.
- Any byte accepted while in FULL_WAIT SHALL be discarded and SHALL set overflow.
REQ-022 ena=0 in COLLECT SHALL discard held bytes and return to IDLE next edge; FIFO contents and FULL_WAIT SHALL be unaffected.
REQ-023 overflow SHALL stay high until an edge with clr_ovf=1; a clr_ovf and a new overflow event on the same edge SHALL leave overflow=1.
REQ-024 frame_count SHALL increment once per successful push and SHALL wrap 255->0.
REQ-025 frame_out and frame_parity SHALL be 0 when frame_valid=0.
REQ-026 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full/empty derived from an occupancy counter of width clog2(FIFO_DEPTH+1).

Reset
REQ-027 rst_n=0 SHALL immediately force FSM=IDLE, FIFO empty, frame_valid=0, frame_out=0, frame_parity=0, overflow=0 and frame_count=0.
REQ-028 Reset asserted mid-frame or with frames buffered SHALL discard all of them; the first byte accepted after release SHALL be byte 0.

Structure
REQ-029 The shared package prg_pkg SHALL hold FRAME_BYTES, FIFO_DEPTH, the byte/frame width constants and the FSM state encoding.
REQ-030 Buffering SHALL be a single sub-module prg_frame_fifo (push/pop, full/empty, data 25 bits = frame plus parity); the assembler and flags SHALL stay in the top module.

Verification
REQ-031 Bytes 0xA5, 0x3C, 0x0F, one per cycle, frame_ready=1 -> frame_valid high one cycle after the 0x0F edge; frame_out=0xA53C0F; frame_parity=0; frame_count=1.
REQ-032 frame_ready=0, three frames sent -> frames 1 and 2 buffered, FSM in FULL_WAIT; a 10th byte sets overflow=1; a frame_ready pulse pops frame 1, frame 3 enters the FIFO, frame_count=3.
REQ-033 Bytes 0x11, 0x22, then ena=0 for one cycle, then bytes 0x33, 0x44, 0x55 -> one frame 0xDDDDDD-free output: frame_out=0x334455, with no 0x11 or 0x22 emitted.
REQ-034 FIFO full with the final byte accepted on the same edge as a pop -> occupancy stays 2, overflow=0, frame order preserved.
REQ-035 rst_n driven low asynchronously between clock edges with 1 frame plus 2 bytes held -> outputs zero immediately; after release, bytes 0x01, 0x02, 0x03 give frame_out=0x010203 and frame_count=1.
REQ-036 256 frames sent with frame_ready=1 -> frame_count wraps to 0; clr_ovf=1 on the same edge as an overflow event leaves overflow=1.
